// File: rtl/klingon_display_scanner.sv
// Time-multiplexed scan controller sharing one digit decoder across NUM_DIGITS positions.
// A double-buffered value store lets a new word take effect only at a frame boundary.
module klingon_display_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int PRESCALE   = 4,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  output logic                    wr_ready,
  output logic [3:0]              dec_in,
  output logic                    dec_blank,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done,
  output logic                    err
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [IW-1:0] LAST_DIGIT = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT   = CW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [IW-1:0]   digit, digit_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic [DW-1:0]   active, active_next;
  logic [DW-1:0]   pending, pending_next;
  logic            pending_full, pending_full_next;
  logic            err_next;
  logic            accept;
  logic            boundary;

  logic [3:0]            dec_in_next;
  logic                  dec_blank_next;
  logic [NUM_DIGITS-1:0] digit_en_next;
  logic                  frame_done_next;
  logic                  wr_ready_next;

  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  zero_run;
  logic [3:0]            nib;
  logic                  lz_sel;

  function automatic logic has_bad_nibble(input logic [DW-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Handshake: a word transfers on any rising edge where wr_valid and wr_ready
  // are both high; wr_valid held while wr_ready is low has no effect.
  always_comb begin
    state_next        = state;
    digit_next        = digit;
    cnt_next          = cnt;
    active_next       = active;
    pending_next      = pending;
    pending_full_next = pending_full;
    err_next          = err;
    accept            = wr_valid && wr_ready;
    boundary          = (state == GAP) && (digit == LAST_DIGIT);

    case (state)
      IDLE: begin
        if (accept) begin
          active_next = wr_data;
          state_next  = ON;
          digit_next  = '0;
          cnt_next    = '0;
        end
      end
      ON: begin
        if (cnt == LAST_CNT) begin
          state_next = GAP;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      GAP: begin
        state_next = ON;
        cnt_next   = '0;
        if (boundary) digit_next = '0;
        else          digit_next = digit + IW'(1);
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A full pending buffer can never coincide with an accepted write, so the
    // swap and the pending fill below are mutually exclusive.
    if (boundary && pending_full) begin
      active_next       = pending;
      pending_full_next = 1'b0;
    end
    if (accept && (state != IDLE)) begin
      pending_next      = wr_data;
      pending_full_next = 1'b1;
    end
    if (accept) err_next = has_bad_nibble(wr_data);
  end

  // Outputs are derived from next-state values so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (active_next[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_run;
    end

    nib    = 4'd0;
    lz_sel = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_next == IW'(i)) begin
        nib    = active_next[4*i +: 4];
        lz_sel = upper_zero[i];
      end
    end

    dec_in_next     = 4'd0;
    dec_blank_next  = 1'b1;
    digit_en_next   = '0;
    frame_done_next = 1'b0;
    wr_ready_next   = (state_next == IDLE) || !pending_full_next;

    if (state_next == ON) begin
      digit_en_next = NUM_DIGITS'(1) << digit_next;
      if (!((nib > 4'd9) || (BLANK_LZ && (digit_next != '0) && lz_sel))) begin
        dec_blank_next = 1'b0;
        dec_in_next    = nib;
      end
    end
    if ((state_next == GAP) && (digit_next == LAST_DIGIT)) frame_done_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      digit        <= '0;
      cnt          <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      err          <= 1'b0;
      dec_in       <= 4'd0;
      dec_blank    <= 1'b1;
      digit_en     <= '0;
      frame_done   <= 1'b0;
      wr_ready     <= 1'b1;
    end else begin
      state        <= state_next;
      digit        <= digit_next;
      cnt          <= cnt_next;
      active       <= active_next;
      pending      <= pending_next;
      pending_full <= pending_full_next;
      err          <= err_next;
      dec_in       <= dec_in_next;
      dec_blank    <= dec_blank_next;
      digit_en     <= digit_en_next;
      frame_done   <= frame_done_next;
      wr_ready     <= wr_ready_next;
    end
  end

endmodule

// File: tb/tb_klingon_display_scanner.sv
// Bench for klingon_display_scanner: two instances (4 digits/prescale 4/LZ blanking and
// 2 digits/prescale 1/no blanking) compared every cycle against a frame-position model.
module tb_klingon_display_scanner;

  typedef struct {
    bit          idle;
    int          pos;
    logic [15:0] active;
    logic [15:0] pending;
    bit          pfull;
    bit          err;
  } model_t;

  typedef struct {
    logic [3:0] dec;
    logic       blank;
    logic [3:0] en;
    logic       fd;
    logic       ready;
    logic       err;
  } exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // instance A: 4 digits, prescale 4, leading-zero blanking
  logic        a_valid;
  logic [15:0] a_data;
  logic        a_ready, a_blank, a_fd, a_err;
  logic [3:0]  a_dec, a_en;

  // instance B: 2 digits, prescale 1, all digits shown
  logic        b_valid;
  logic [7:0]  b_data;
  logic        b_ready, b_blank, b_fd, b_err;
  logic [3:0]  b_dec;
  logic [1:0]  b_en;

  klingon_display_scanner #(.NUM_DIGITS(4), .PRESCALE(4), .BLANK_LZ(1'b1)) dut_a (
    .clk(clk), .reset(reset), .wr_valid(a_valid), .wr_data(a_data), .wr_ready(a_ready),
    .dec_in(a_dec), .dec_blank(a_blank), .digit_en(a_en), .frame_done(a_fd), .err(a_err)
  );

  klingon_display_scanner #(.NUM_DIGITS(2), .PRESCALE(1), .BLANK_LZ(1'b0)) dut_b (
    .clk(clk), .reset(reset), .wr_valid(b_valid), .wr_data(b_data), .wr_ready(b_ready),
    .dec_in(b_dec), .dec_blank(b_blank), .digit_en(b_en), .frame_done(b_fd), .err(b_err)
  );

  int     err_cnt = 0;
  int     chk_cnt = 0;
  model_t ma, mb;
  bit     b_rand;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit bad_word(input logic [15:0] w);
    bit b;
    b = 1'b0;
    for (int i = 0; i < 4; i++) if (((w >> (4*i)) & 16'hF) > 16'd9) b = 1'b1;
    return b;
  endfunction

  // Display position is a single counter over the frame; digit and on/gap
  // phase fall out of division by the slot length (PRESCALE+1).
  function automatic exp_t model_out(input model_t m, input int n, input int p, input bit lz);
    exp_t        e;
    int          d, r;
    logic [15:0] up;
    e.dec   = 4'd0;
    e.blank = 1'b1;
    e.en    = 4'd0;
    e.fd    = 1'b0;
    e.ready = m.idle || !m.pfull;
    e.err   = m.err;
    if (!m.idle) begin
      d = m.pos / (p + 1);
      r = m.pos % (p + 1);
      if (r < p) begin
        up   = m.active >> (4*d);
        e.en = 4'(1 << d);
        if (!(up[3:0] > 4'd9 || (lz && d > 0 && up == 16'd0))) begin
          e.blank = 1'b0;
          e.dec   = up[3:0];
        end
      end else begin
        e.fd = (d == n - 1);
      end
    end
    return e;
  endfunction

  function automatic model_t model_step(input model_t m, input int n, input int p,
                                        input bit rst, input bit valid, input logic [15:0] data);
    model_t r;
    bit     acc;
    int     f;
    r = m;
    f = n * (p + 1);
    if (rst) begin
      r.idle = 1; r.pos = 0; r.active = '0; r.pending = '0; r.pfull = 0; r.err = 0;
      return r;
    end
    acc = valid && (m.idle || !m.pfull);
    if (m.idle) begin
      if (acc) begin
        r.active = data; r.idle = 0; r.pos = 0;
      end
    end else begin
      if (m.pos == f - 1 && m.pfull) begin
        r.active = m.pending; r.pfull = 0;
      end
      if (acc) begin
        r.pending = data; r.pfull = 1;
      end
      r.pos = (m.pos + 1) % f;
    end
    if (acc) r.err = bad_word(data);
    return r;
  endfunction

  task automatic compare_all();
    exp_t ea, eb;
    ea = model_out(ma, 4, 4, 1'b1);
    eb = model_out(mb, 2, 1, 1'b0);
    check("a_dec_in",     a_dec,   ea.dec);
    check("a_dec_blank",  a_blank, ea.blank);
    check("a_digit_en",   a_en,    ea.en);
    check("a_frame_done", a_fd,    ea.fd);
    check("a_wr_ready",   a_ready, ea.ready);
    check("a_err",        a_err,   ea.err);
    check("b_dec_in",     b_dec,   eb.dec);
    check("b_dec_blank",  b_blank, eb.blank);
    check("b_digit_en",   b_en,    eb.en);
    check("b_frame_done", b_fd,    eb.fd);
    check("b_wr_ready",   b_ready, eb.ready);
    check("b_err",        b_err,   eb.err);
  endtask

  function automatic logic [15:0] rand_word(input int n);
    logic [15:0] w;
    w = 16'($urandom);
    if ($urandom_range(0, 1) == 0) w = w & 16'h0F0F;
    if ($urandom_range(0, 2) == 0) w = w & 16'h00FF;
    if ($urandom_range(0, 1) == 0) w = w & 16'h7777;
    if (n == 2) w = w & 16'h00FF;
    return w;
  endfunction

  // One clock: model advances on the same edge as the DUT, outputs checked on the falling edge.
  task automatic cycle();
    @(posedge clk);
    ma = model_step(ma, 4, 4, reset, a_valid, a_data);
    mb = model_step(mb, 2, 1, reset, b_valid, {8'h00, b_data});
    @(negedge clk);
    compare_all();
    if (b_rand) begin
      b_valid = ($urandom_range(0, 3) == 0);
      b_data  = 8'(rand_word(2));
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic send_a(input logic [15:0] w);
    bit done;
    done    = 1'b0;
    a_valid = 1'b1;
    a_data  = w;
    for (int k = 0; k < 200 && !done; k++) begin
      done = model_out(ma, 4, 4, 1'b1).ready;
      cycle();
    end
    if (!done) check("a_send_timeout", 32'd0, 32'd1);
    a_valid = 1'b0;
  endtask

  task automatic wait_pos_a(input int target);
    bit hit;
    hit = 1'b0;
    for (int k = 0; k < 200 && !hit; k++) begin
      if (!ma.idle && ma.pos == target) hit = 1'b1;
      else cycle();
    end
    if (!hit) check("a_wait_pos_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset   = 1'b1;
    a_valid = 1'b0;
    a_data  = '0;
    b_valid = 1'b0;
    b_data  = '0;
    b_rand  = 1'b0;
    ma      = model_step(ma, 4, 4, 1'b1, 1'b0, 16'h0);
    mb      = model_step(mb, 2, 1, 1'b1, 1'b0, 16'h0);
    @(negedge clk);
    run(3);
    reset = 1'b0;
    run(2);

    // basic scan on both instances
    b_valid = 1'b1;
    b_data  = 8'h57;
    a_valid = 1'b1;
    a_data  = 16'h1234;
    cycle();
    a_valid = 1'b0;
    b_valid = 1'b0;
    run(24);

    // leading zeros, all-zero, invalid digit, err clear
    b_rand = 1'b1;
    send_a(16'h0070); run(45);
    send_a(16'h0000); run(45);
    send_a(16'h12A4); run(45);
    send_a(16'h0009); run(45);

    // backpressure: pending fill mid-frame, second write held off until boundary
    send_a(16'h1111); run(40);
    wait_pos_a(7);
    send_a(16'h2222);
    send_a(16'h3333);
    run(50);

    // reset during digit 2 ON with a pending word outstanding
    send_a(16'h4321);
    send_a(16'h5555);
    wait_pos_a(11);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    run(12);

    // randomized traffic with occasional resets
    for (int k = 0; k < 3000; k++) begin
      a_valid = ($urandom_range(0, 3) == 0);
      a_data  = rand_word(4);
      reset   = ($urandom_range(0, 299) == 0);
      cycle();
    end
    reset   = 1'b0;
    a_valid = 1'b0;
    run(5);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
